ifetch_queue: RTL and testbench

Instruction-fetch front end of the pipelined CPU: owns the program counter, issues reads to the instruction SRAM (sram0), and buffers returned words in a small prefetch queue. It delivers instructions with their PCs to the decode stage over a valid/ready handshake. It also accepts a redirect (branch/jump/interrupt target) from execute, which flushes all buffered and in-flight fetches.

---
 rtl/ifetch_pkg.sv | 15 +
 rtl/ifq_fifo.sv | 62 ++++++
 rtl/ifetch_queue.sv | 93 +++++++++
 tb/tb_ifetch_queue.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// Shared defaults and types for the instruction-fetch front end.
package ifetch_pkg;

    localparam int IFQ_ADDR_WIDTH = 16;
    localparam int IFQ_DATA_WIDTH = 16;
    localparam int IFQ_DEPTH      = 4;

    localparam logic [IFQ_ADDR_WIDTH-1:0] IFQ_RESET_PC = '0;

    typedef struct packed {
        logic [IFQ_DATA_WIDTH-1:0] inst;
        logic [IFQ_ADDR_WIDTH-1:0] pc;
    } ifq_entry_t;

endpackage

// File: rtl/ifq_fifo.sv
// Synchronous DEPTH-entry FIFO for the prefetch queue; flush dominates push and pop.
module ifq_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_push_data,
    input  logic                       i_pop,
    input  logic                       i_flush,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_valid,
    output logic [WIDTH-1:0]           o_head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && ((r_count != CNT_W'(DEPTH)) || w_do_pop);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; the head is forced to zero
    // whenever the queue is empty, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_push_data;
    end

    assign o_count = r_count;
    assign o_valid = (r_count != '0);
    assign o_head  = o_valid ? r_mem[r_rd_ptr] : '0;

endmodule

// File: rtl/ifetch_queue.sv
// Fetch front end: owns the PC, issues sram0 reads, buffers returned words
// for decode, and restarts fetch on a redirect from execute.
module ifetch_queue
    import ifetch_pkg::*;
#(
    parameter int ADDR_WIDTH = IFQ_ADDR_WIDTH,
    parameter int DATA_WIDTH = IFQ_DATA_WIDTH,
    parameter int DEPTH      = IFQ_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  fetch_en,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic [ADDR_WIDTH-1:0] inst_addr,
    output logic                  inst_rd_n,
    input  logic [DATA_WIDTH-1:0] inst_in,
    output logic                  dec_valid,
    output logic [DATA_WIDTH-1:0] dec_inst,
    output logic [ADDR_WIDTH-1:0] dec_pc,
    input  logic                  dec_ready
);

    localparam int CNT_W   = $clog2(DEPTH+1);
    localparam int ENTRY_W = DATA_WIDTH + ADDR_WIDTH;

    logic [ADDR_WIDTH-1:0] r_fetch_pc;
    logic [ADDR_WIDTH-1:0] r_inflight_pc;
    logic [ADDR_WIDTH-1:0] r_inst_addr;
    logic                  r_inflight;
    logic                  r_inst_rd_n;

    logic [CNT_W-1:0]      w_count;
    logic [CNT_W:0]        w_occupancy;
    logic                  w_room;
    logic                  w_issue;
    logic [ADDR_WIDTH-1:0] w_issue_pc;
    logic                  w_push;
    logic                  w_pop;
    logic [ENTRY_W-1:0]    w_head;

    // Reserving a slot for the in-flight read keeps the queue from overflowing.
    assign w_occupancy = {1'b0, w_count} + {{CNT_W{1'b0}}, r_inflight};
    assign w_room      = w_occupancy < (CNT_W+1)'(DEPTH);

    // A redirect empties the queue and kills the in-flight word, so it may
    // always issue regardless of current occupancy.
    assign w_issue    = fetch_en && (redirect_valid || w_room);
    assign w_issue_pc = redirect_valid ? redirect_pc : r_fetch_pc;
    assign w_push     = r_inflight && !redirect_valid;
    assign w_pop      = dec_valid && dec_ready && !redirect_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fetch_pc    <= ADDR_WIDTH'(IFQ_RESET_PC);
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
            r_inst_addr   <= '0;
            r_inst_rd_n   <= 1'b1;
        end else if (w_issue) begin
            r_inst_addr   <= w_issue_pc;
            r_inst_rd_n   <= 1'b0;
            r_inflight    <= 1'b1;
            r_inflight_pc <= w_issue_pc;
            r_fetch_pc    <= w_issue_pc + 1'b1;
        end else begin
            r_inst_rd_n   <= 1'b1;
            r_inflight    <= 1'b0;
            if (redirect_valid) r_fetch_pc <= redirect_pc;
        end
    end

    ifq_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_push      (w_push),
        .i_push_data ({inst_in, r_inflight_pc}),
        .i_pop       (w_pop),
        .i_flush     (redirect_valid),
        .o_count     (w_count),
        .o_valid     (dec_valid),
        .o_head      (w_head)
    );

    assign inst_addr = r_inst_addr;
    assign inst_rd_n = r_inst_rd_n;
    assign dec_inst  = w_head[ENTRY_W-1:ADDR_WIDTH];
    assign dec_pc    = w_head[ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue against a queue-based reference model.
module tb_ifetch_queue;
    import ifetch_pkg::*;

    localparam int AW    = IFQ_ADDR_WIDTH;
    localparam int DW    = IFQ_DATA_WIDTH;
    localparam int DEPTH = IFQ_DEPTH;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          fetch_en;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic [AW-1:0] inst_addr;
    logic          inst_rd_n;
    logic [DW-1:0] inst_in;
    logic          dec_valid;
    logic [DW-1:0] dec_inst;
    logic [AW-1:0] dec_pc;
    logic          dec_ready;

    always #5 clk = ~clk;

    // sram0 model: word at address a is 0xA000+a; garbage when not strobed.
    assign inst_in = inst_rd_n ? 16'h5A5A : (16'hA000 + inst_addr);

    ifetch_queue dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_addr      (inst_addr),
        .inst_rd_n      (inst_rd_n),
        .inst_in        (inst_in),
        .dec_valid      (dec_valid),
        .dec_inst       (dec_inst),
        .dec_pc         (dec_pc),
        .dec_ready      (dec_ready)
    );

    int n_checks;
    int n_fail;

    ifq_entry_t    m_q[$];
    logic          m_infl;
    logic [AW-1:0] m_infl_pc;
    logic [AW-1:0] m_fpc;
    logic [AW-1:0] m_addr;
    logic          m_rd_n;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_infl    = 1'b0;
        m_infl_pc = '0;
        m_fpc     = '0;
        m_addr    = '0;
        m_rd_n    = 1'b1;
    endtask

    task automatic model_issue(input logic [AW-1:0] pc);
        m_addr    = pc;
        m_rd_n    = 1'b0;
        m_infl    = 1'b1;
        m_infl_pc = pc;
        m_fpc     = pc + 16'd1;
    endtask

    // One clock edge of the fetch unit, expressed as queue operations.
    task automatic model_step();
        int         occ;
        ifq_entry_t e;
        if (redirect_valid) begin
            m_q.delete();
            m_infl = 1'b0;
            if (fetch_en) model_issue(redirect_pc);
            else begin
                m_rd_n = 1'b1;
                m_fpc  = redirect_pc;
            end
            return;
        end
        occ = m_q.size() + int'(m_infl);
        if (dec_ready && m_q.size() != 0) m_q.delete(0);
        if (m_infl) begin
            e.pc   = m_infl_pc;
            e.inst = 16'hA000 + m_infl_pc;
            m_q.push_back(e);
        end
        if (fetch_en && occ < DEPTH) model_issue(m_fpc);
        else begin
            m_rd_n = 1'b1;
            m_infl = 1'b0;
        end
    endtask

    task automatic compare_all();
        check("dec_valid", dec_valid, m_q.size() != 0);
        if (m_q.size() != 0) begin
            check("dec_pc", dec_pc, m_q[0].pc);
            check("dec_inst", dec_inst, m_q[0].inst);
        end
        check("inst_rd_n", inst_rd_n, m_rd_n);
        check("inst_addr", inst_addr, m_addr);
    endtask

    // Inputs change only on the falling edge; outputs are compared there too.
    task automatic cycle();
        @(posedge clk);
        if (reset_n) model_step();
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        logic [AW-1:0] held_pc;
        logic [AW-1:0] wrap_exp [4];
        n_checks       = 0;
        n_fail         = 0;
        reset_n        = 1'b0;
        fetch_en       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        dec_ready      = 1'b1;
        model_reset();

        repeat (2) @(negedge clk);
        check("rst_dec_valid", dec_valid, 0);
        check("rst_rd_n", inst_rd_n, 1);
        check("rst_addr", inst_addr, 0);
        check("rst_dec_inst", dec_inst, 0);
        check("rst_dec_pc", dec_pc, 0);

        // First instruction reaches decode after the second edge.
        reset_n = 1'b1;
        cycle();
        check("first_e1_valid", dec_valid, 0);
        cycle();
        check("first_e2_valid", dec_valid, 1);
        check("first_e2_pc", dec_pc, 0);
        check("first_e2_inst", dec_inst, 16'hA000);
        repeat (6) cycle();

        // Decode stalls: queue fills, issue stops, head holds.
        dec_ready = 1'b0;
        held_pc   = m_q[0].pc;
        repeat (10) cycle();
        check("stall_rd_n", inst_rd_n, 1);
        check("stall_head", dec_pc, held_pc);
        check("stall_full", m_q.size(), DEPTH);

        // One pop, then an issue refills: 3 queued + 1 in flight, then redirect.
        dec_ready = 1'b1;
        cycle();
        dec_ready = 1'b0;
        cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0040;
        cycle();
        redirect_valid = 1'b0;
        dec_ready      = 1'b1;
        cycle();
        check("redir_pc0", dec_pc, 16'h0040);
        cycle();
        check("redir_pc1", dec_pc, 16'h0041);

        // Redirect coinciding with a pop: the pop is dropped.
        repeat (3) cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0123;
        cycle();
        check("rp_empty", dec_valid, 0);
        redirect_valid = 1'b0;
        cycle();
        check("rp_pc", dec_pc, 16'h0123);

        // Address wrap at the top of the space.
        redirect_valid = 1'b1;
        redirect_pc    = 16'hFFFE;
        cycle();
        redirect_valid = 1'b0;
        wrap_exp = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("wrap_pc", dec_pc, wrap_exp[i]);
        end

        // Asynchronous reset with a full queue.
        dec_ready = 1'b0;
        repeat (8) cycle();
        #2 reset_n = 1'b0;
        #1;
        check("arst_valid", dec_valid, 0);
        check("arst_rd_n", inst_rd_n, 1);
        check("arst_addr", inst_addr, 0);
        model_reset();
        cycle();
        reset_n   = 1'b1;
        dec_ready = 1'b1;
        cycle();
        cycle();
        check("arst_restart_pc", dec_pc, 0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            fetch_en       = ($urandom_range(0, 7) != 0);
            dec_ready      = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 15) == 0);
            redirect_pc    = ($urandom_range(0, 3) == 0) ? (16'hFFFC | 16'($urandom_range(0, 3)))
                                                         : 16'($urandom);
            cycle();
        end
        redirect_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
